er_metric_unit: RTL and testbench
=================================

# er_metric_unit

Hardware error-metric accumulator for approximate-adder characterisation. It consumes each operand pair (a, b) and the approximate sum an adder-under-test produces for it. Internally it forms the exact N-bit sum, then accumulates error count, total error distance, maximum error distance and zero-exact count over a programmed number of samples. It sits directly downstream of the approximate adder in on-chip or FPGA error-rate runs; software derives ER, MED and NMED from its counters.

## Interface
- N, 16, operand/sum width
- CNT_W, 32, sample-counter width
- ACC_W, N+CNT_W, error-distance accumulator width (cannot overflow for ≤2^CNT_W−1 samples)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a run; honoured only in IDLE or DONE
- num_samples  in  CNT_W  samples in the run; sampled on accepted start
- in_valid  in  1  sample present on a, b, approx_sum
- in_ready  out  1  unit accepts a sample this cycle
- a, b  in  N  operands fed to the adder under test
- approx_sum  in  N  approximate sum from the adder under test
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE (level, not pulse)
- sample_count  out  CNT_W  samples accepted this run
- err_count  out  CNT_W  samples with approx_sum != exact
- sum_ed  out  ACC_W  Σ|approx_sum − exact|
- max_ed  out  N  max |approx_sum − exact|
- zero_exact_count  out  CNT_W  samples with exact == 0 (excluded from MRED by software)

## Operation
- Exact sum = (a + b) mod 2^N, with carry-out discarded.
- Error distance ed = |approx_sum − exact|, computed unsigned on N bits. The larger value minus the smaller gives an N-bit result.
- States:
  - IDLE: entered on reset. On start, the unit clears all accumulators and sample_count and latches num_samples into target. It goes to RUN if target ≠ 0, otherwise straight to DONE.
  - RUN: in_ready = (sample_count < target). A sample is accepted when in_valid && in_ready; the accept increments sample_count and loads pipeline stage 1. When the accept raises sample_count to target, the state goes to DRAIN.
  - DRAIN: in_ready = 0. After the stage-2 update of the last sample, the state goes to DONE.
  - DONE: done = 1; outputs hold. On start, the unit clears and restarts exactly as from IDLE.
- start is ignored in RUN and DRAIN.
- in_valid with in_ready = 0 is dropped; it is not queued.
- Pipeline:
  - Stage 1 registers exact, approx_sum and a valid bit.
  - Stage 2 updates the counters from the stage-1 registers when the valid bit is set:
    - err_count increments if ed ≠ 0.
    - sum_ed adds ed.
    - max_ed takes ed if ed > max_ed.
    - zero_exact_count increments if exact == 0.
- Reset, including mid-run, immediately forces IDLE. It clears every output counter and pipeline valid; the in-flight sample is discarded.

## Timing
- Reset values: in_ready=0, busy=0, done=0, sample_count=0, err_count=0, sum_ed=0, max_ed=0, zero_exact_count=0.
- start at edge t (IDLE/DONE):
  - Counters read 0 after t.
  - If target ≠ 0: state RUN after t, so in_ready is high in the cycle after t.
  - If target = 0: done=1 after t.
- sample_count updates at the accept edge k; the error counters update at edge k+1.
- Last accept at edge t: DRAIN after t, final counters after t+1, DONE (done=1, busy=0) after t+2.
- Throughput: one sample per cycle with in_valid held high, so a run of S samples takes S+2 cycles from first accept to done.
- done drops on the edge that accepts a new start.

## Test plan
- num_samples=4, samples (a,b,approx) = (3,5,8), (100,50,140), (0xFFFF,0x0001,0x0003), (10,20,5) -> err_count=3, sum_ed=38, max_ed=25, zero_exact_count=1, sample_count=4, done 2 cycles after the 4th accept.
- num_samples=2, samples (0x4000,0x4000,0x0000) and (0x0000,0x0000,0xFFFF) -> ed 0x8000 then 0xFFFF; max_ed=0xFFFF, sum_ed=0x17FFF (needs >N bits), err_count=2, zero_exact_count=1.
- num_samples=3 with in_valid toggling every other cycle, then in_valid held high 5 more cycles -> exactly 3 accepts, in_ready=0 after the 3rd, sample_count=3, extras ignored.
- num_samples=0 -> done=1 one edge after start, all counters 0, in_ready never high.
- Run of 8 samples with rst asserted after 5 accepts -> all outputs 0 immediately (asynchronous), state IDLE. A fresh start with num_samples=1 and sample (1,1,3) -> err_count=1, sum_ed=1.
- From DONE with err_count≠0, start pulsed during RUN is ignored. A start in DONE with num_samples=1 and sample (7,7,14) -> all error counters 0, sample_count=1.

Source files
------------

// File: rtl/er_metric_unit.sv
// Error-metric accumulator for characterising an approximate adder: compares each
// approximate sum with the exact N-bit sum and gathers ER/MED statistics over a run.
module er_metric_unit #(
    parameter int N     = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = N + CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [N-1:0]     max_ed,
    output logic [CNT_W-1:0] zero_exact_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_sample_count;
    logic             r_s1_valid;
    logic [N-1:0]     r_s1_exact;
    logic [N-1:0]     r_s1_approx;
    logic [CNT_W-1:0] r_err_count;
    logic [ACC_W-1:0] r_sum_ed;
    logic [N-1:0]     r_max_ed;
    logic [CNT_W-1:0] r_zero_count;

    logic             w_start_ok;
    logic             w_accept;
    logic             w_in_ready;
    logic [CNT_W-1:0] w_count_inc;
    logic [N-1:0]     w_exact;
    logic [N-1:0]     w_ed;

    // Carry-out is deliberately dropped: the reference is the N-bit wrapped sum.
    assign w_exact     = a + b;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_in_ready  = (r_state == S_RUN) && (r_sample_count < r_target);
    assign w_accept    = in_valid && w_in_ready;
    assign w_count_inc = r_sample_count + CNT_W'(1);
    assign w_ed        = (r_s1_approx >= r_s1_exact) ? (r_s1_approx - r_s1_exact)
                                                     : (r_s1_exact - r_s1_approx);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = (num_samples != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_accept && (w_count_inc == r_target)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Stage 1 empties one edge after the last accept; leave once stage 2 has used it.
                if (!r_s1_valid) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_target       <= '0;
            r_sample_count <= '0;
            r_s1_valid     <= 1'b0;
            r_s1_exact     <= '0;
            r_s1_approx    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_s1_valid <= w_accept;
            if (w_start_ok) begin
                r_target       <= num_samples;
                r_sample_count <= '0;
            end else if (w_accept) begin
                r_sample_count <= w_count_inc;
            end
            if (w_accept) begin
                r_s1_exact  <= w_exact;
                r_s1_approx <= approx_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count  <= '0;
            r_sum_ed     <= '0;
            r_max_ed     <= '0;
            r_zero_count <= '0;
        end else if (w_start_ok) begin
            r_err_count  <= '0;
            r_sum_ed     <= '0;
            r_max_ed     <= '0;
            r_zero_count <= '0;
        end else if (r_s1_valid) begin
            if (w_ed != '0) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
            r_sum_ed <= r_sum_ed + ACC_W'(w_ed);
            if (w_ed > r_max_ed) begin
                r_max_ed <= w_ed;
            end
            if (r_s1_exact == '0) begin
                r_zero_count <= r_zero_count + CNT_W'(1);
            end
        end
    end

    assign in_ready         = w_in_ready;
    assign busy             = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done             = (r_state == S_DONE);
    assign sample_count     = r_sample_count;
    assign err_count        = r_err_count;
    assign sum_ed           = r_sum_ed;
    assign max_ed           = r_max_ed;
    assign zero_exact_count = r_zero_count;

endmodule

// File: tb/tb_er_metric_unit.sv
// Directed bench for er_metric_unit; expected values are worked out by hand from
// the operand/approximate-sum vectors in each scenario.
module tb_er_metric_unit;

    localparam int N     = 16;
    localparam int CNT_W = 32;
    localparam int ACC_W = N + CNT_W;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [N-1:0]     approx_sum;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] sum_ed;
    logic [N-1:0]     max_ed;
    logic [CNT_W-1:0] zero_exact_count;

    int checks;
    int failures;

    er_metric_unit #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .num_samples      (num_samples),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .a                (a),
        .b                (b),
        .approx_sum       (approx_sum),
        .busy             (busy),
        .done             (done),
        .sample_count     (sample_count),
        .err_count        (err_count),
        .sum_ed           (sum_ed),
        .max_ed           (max_ed),
        .zero_exact_count (zero_exact_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] ns);
        num_samples = ns;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic drive(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [N-1:0] sv);
        a          = av;
        b          = bv;
        approx_sum = sv;
        in_valid   = 1'b1;
        step();
        $display("sample a=%04h b=%04h approx=%04h count=%0d", av, bv, sv, sample_count);
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (sample_count !== 32'd0) begin failures++; $display("FAIL reset_sample_count got=%0d exp=0", sample_count); end
        checks++; if (err_count !== 32'd0 || sum_ed !== 48'd0 || max_ed !== 16'd0 || zero_exact_count !== 32'd0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d/%0d/%0d exp=0/0/0/0", err_count, sum_ed, max_ed, zero_exact_count);
        end
    endtask

    task automatic test_basic();
        do_start(32'd4);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_run got busy=%0b ready=%0b exp=1/1", busy, in_ready); end
        checks++; if (sample_count !== 32'd0) begin failures++; $display("FAIL basic_start_count got=%0d exp=0", sample_count); end
        drive(16'd3, 16'd5, 16'd8);
        drive(16'd100, 16'd50, 16'd140);
        drive(16'hFFFF, 16'h0001, 16'h0003);
        drive(16'd10, 16'd20, 16'd5);
        in_valid = 1'b0;
        checks++; if (sample_count !== 32'd4) begin failures++; $display("FAIL basic_count got=%0d exp=4", sample_count); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL basic_drain got ready=%0b busy=%0b done=%0b exp=0/1/0", in_ready, busy, done);
        end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_early got=%0b exp=0", done); end
        checks++; if (err_count !== 32'd3) begin failures++; $display("FAIL basic_err got=%0d exp=3", err_count); end
        checks++; if (sum_ed !== 48'd38) begin failures++; $display("FAIL basic_sum_ed got=%0d exp=38", sum_ed); end
        checks++; if (max_ed !== 16'd25) begin failures++; $display("FAIL basic_max_ed got=%0d exp=25", max_ed); end
        checks++; if (zero_exact_count !== 32'd1) begin failures++; $display("FAIL basic_zero got=%0d exp=1", zero_exact_count); end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done got done=%0b busy=%0b exp=1/0", done, busy); end
        $display("basic run err=%0d sum_ed=%0d max_ed=%0d zero=%0d", err_count, sum_ed, max_ed, zero_exact_count);
    endtask

    task automatic test_wide_ed();
        do_start(32'd2);
        drive(16'h4000, 16'h4000, 16'h0000);
        drive(16'h0000, 16'h0000, 16'hFFFF);
        in_valid = 1'b0;
        step();
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL wide_done got=%0b exp=1", done); end
        checks++; if (max_ed !== 16'hFFFF) begin failures++; $display("FAIL wide_max_ed got=%0h exp=ffff", max_ed); end
        checks++; if (sum_ed !== 48'h17FFF) begin failures++; $display("FAIL wide_sum_ed got=%0h exp=17fff", sum_ed); end
        checks++; if (err_count !== 32'd2 || zero_exact_count !== 32'd1) begin
            failures++; $display("FAIL wide_counts got err=%0d zero=%0d exp=2/1", err_count, zero_exact_count);
        end
    endtask

    task automatic test_valid_toggle();
        int accepts;
        accepts = 0;
        do_start(32'd3);
        for (int i = 0; i < 6; i++) begin
            in_valid   = (i % 2 == 0);
            a          = 16'(i);
            b          = 16'd1;
            approx_sum = 16'(i + 1);
            if (i == 5) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL toggle_ready_after_3 got=%0b exp=0", in_ready); end
            end
            if (in_valid && in_ready) accepts++;
            step();
        end
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (in_valid && in_ready) accepts++;
            step();
        end
        in_valid = 1'b0;
        $display("toggle run accepts=%0d count=%0d", accepts, sample_count);
        checks++; if (accepts !== 3) begin failures++; $display("FAIL toggle_accepts got=%0d exp=3", accepts); end
        checks++; if (sample_count !== 32'd3) begin failures++; $display("FAIL toggle_count got=%0d exp=3", sample_count); end
        checks++; if (done !== 1'b1 || err_count !== 32'd0) begin failures++; $display("FAIL toggle_done got done=%0b err=%0d exp=1/0", done, err_count); end
    endtask

    task automatic test_zero_samples();
        int ready_seen;
        ready_seen = 0;
        do_start(32'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_done got done=%0b busy=%0b exp=1/0", done, busy); end
        checks++; if (sample_count !== 32'd0 || err_count !== 32'd0 || sum_ed !== 48'd0 || max_ed !== 16'd0 || zero_exact_count !== 32'd0) begin
            failures++; $display("FAIL zero_counters got %0d/%0d/%0d/%0d/%0d exp=0", sample_count, err_count, sum_ed, max_ed, zero_exact_count);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (in_ready) ready_seen++;
            step();
        end
        in_valid = 1'b0;
        checks++; if (ready_seen !== 0) begin failures++; $display("FAIL zero_ready got=%0d exp=0", ready_seen); end
        $display("zero run done=%0b count=%0d", done, sample_count);
    endtask

    task automatic test_mid_reset();
        do_start(32'd8);
        for (int i = 0; i < 5; i++) begin
            drive(16'(i), 16'd0, 16'(i + 2));
        end
        checks++; if (sum_ed !== 48'd8 || sample_count !== 32'd5) begin
            failures++; $display("FAIL midrst_pre got sum=%0d count=%0d exp=8/5", sum_ed, sample_count);
        end
        #1 rst = 1'b1;
        #1;
        checks++; if (sample_count !== 32'd0 || err_count !== 32'd0 || sum_ed !== 48'd0 || max_ed !== 16'd0) begin
            failures++; $display("FAIL midrst_async got %0d/%0d/%0d/%0d exp=0", sample_count, err_count, sum_ed, max_ed);
        end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL midrst_idle got busy=%0b done=%0b ready=%0b exp=0/0/0", busy, done, in_ready);
        end
        #1 rst = 1'b0;
        in_valid = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_stay_idle got busy=%0b done=%0b exp=0/0", busy, done); end
        do_start(32'd1);
        drive(16'd1, 16'd1, 16'd3);
        in_valid = 1'b0;
        step();
        step();
        checks++; if (done !== 1'b1 || err_count !== 32'd1 || sum_ed !== 48'd1 || sample_count !== 32'd1) begin
            failures++; $display("FAIL midrst_fresh got done=%0b err=%0d sum=%0d count=%0d exp=1/1/1/1", done, err_count, sum_ed, sample_count);
        end
    endtask

    task automatic test_back_to_back();
        do_start(32'd1);
        checks++; if (done !== 1'b0 || busy !== 1'b1 || err_count !== 32'd0 || sum_ed !== 48'd0 || sample_count !== 32'd0) begin
            failures++; $display("FAIL b2b_clear got done=%0b busy=%0b err=%0d sum=%0d count=%0d exp=0/1/0/0/0", done, busy, err_count, sum_ed, sample_count);
        end
        num_samples = 32'd5;
        start       = 1'b1;
        drive(16'd7, 16'd7, 16'd14);
        in_valid = 1'b0;
        checks++; if (sample_count !== 32'd1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_run_start got count=%0d ready=%0b exp=1/0", sample_count, in_ready);
        end
        step();
        start = 1'b0;
        step();
        checks++; if (done !== 1'b1 || sample_count !== 32'd1) begin
            failures++; $display("FAIL b2b_done got done=%0b count=%0d exp=1/1", done, sample_count);
        end
        checks++; if (err_count !== 32'd0 || sum_ed !== 48'd0 || max_ed !== 16'd0 || zero_exact_count !== 32'd0) begin
            failures++; $display("FAIL b2b_counters got %0d/%0d/%0d/%0d exp=0", err_count, sum_ed, max_ed, zero_exact_count);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        approx_sum  = '0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_basic();
        test_wide_ed();
        test_valid_toggle();
        test_zero_samples();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
